// File: rtl/load_store_unit.sv
// Data-memory access stage of the RV32I core: one load/store at a time over a req/gnt/rvalid bus, loads written back to the regfile.
// Latency: load accept-to-regfile-write is 3 cycles minimum (gnt and rvalid each stretch it); store done pulses in the gnt cycle.
// Backpressure: issue_ready is high only in IDLE; mem_req and its address/enables/data hold stable until mem_gnt. Option macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
   parameter int addr_length    = 32,
   parameter int data_length    = 32,
   parameter int register_count = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              issue_valid,
   output logic                              issue_ready,
   input  logic                              issue_store,
   input  logic [2:0]                        issue_funct3,
   input  logic [addr_length-1:0]            issue_addr,
   input  logic [data_length-1:0]            issue_wdata,
   input  logic [$clog2(register_count)-1:0] issue_rd,
   output logic                              mem_req,
   output logic                              mem_we,
   output logic [addr_length-1:0]            mem_addr,
   output logic [3:0]                        mem_be,
   output logic [data_length-1:0]            mem_wdata,
   input  logic                              mem_gnt,
   input  logic                              mem_rvalid,
   input  logic [data_length-1:0]            mem_rdata,
   output logic [$clog2(register_count)-1:0] w_addr_reg,
   output logic [data_length-1:0]            w_data_reg,
   output logic                              w_ctrl_reg,
   output logic                              done,
   output logic                              misalign_err
);

   localparam int RD_W = $clog2(register_count);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

   typedef struct packed {
      logic                   store;
      logic [2:0]             funct3;
      logic [addr_length-1:0] addr;
      logic [data_length-1:0] wdata;
      logic [RD_W-1:0]        rd;
   } req_t;

   state_t                 state, state_nxt;
   req_t                   req_q;
   logic [data_length-1:0] ld_data_q;

   logic [1:0]             off;
   logic [1:0]             eff_off;
   logic                   is_half;
   logic                   is_word;
   logic                   legal;
   logic                   misaligned;
   logic                   go;
   logic [7:0]             ld_byte;
   logic [15:0]            ld_half;
   logic [data_length-1:0] ld_ext;
   logic [3:0]             st_be;
   logic [data_length-1:0] st_wdata;

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Capture the issued access so the bus fields stay stable for its whole lifetime.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q <= '0;
      end else if (issue_valid && issue_ready) begin
         req_q <= '{store: issue_store, funct3: issue_funct3, addr: issue_addr,
                    wdata: issue_wdata, rd: issue_rd};
      end
   end

   // Load data is extracted as it arrives and held for the writeback cycle.
   always_ff @(posedge clk) begin
      if (rst)                               ld_data_q <= '0;
      else if (state == WAIT && mem_rvalid)  ld_data_q <= ld_ext;
   end

   // Access decode: legality, alignment, lane offset, byte enables, store data and load extraction.
   always_comb begin
      off     = req_q.addr[1:0];
      is_half = (req_q.funct3[1:0] == 2'b01);
      is_word = (req_q.funct3[1:0] == 2'b10);
      if (req_q.store) legal = (req_q.funct3 == 3'b000) || (req_q.funct3 == 3'b001) ||
                               (req_q.funct3 == 3'b010);
      else             legal = (req_q.funct3 == 3'b000) || (req_q.funct3 == 3'b001) ||
                               (req_q.funct3 == 3'b010) || (req_q.funct3 == 3'b100) ||
                               (req_q.funct3 == 3'b101);
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned = (is_half && off[0]) || (is_word && (off != 2'b00));
`else
      misaligned = 1'b0;
`endif
      go = legal && !misaligned;
      // Without the trap, halfword/word offsets are forced to natural alignment.
      if (is_word)      eff_off = 2'b00;
      else if (is_half) eff_off = {off[1], 1'b0};
      else              eff_off = off;

      if (!req_q.store)  st_be = 4'b1111;
      else if (is_word)  st_be = 4'b1111;
      else if (is_half)  st_be = 4'b0011 << eff_off;
      else               st_be = 4'b0001 << eff_off;

      if (!req_q.store)  st_wdata = '0;
      else if (is_word)  st_wdata = req_q.wdata;
      else if (is_half)  st_wdata = {2{req_q.wdata[15:0]}};
      else               st_wdata = {4{req_q.wdata[7:0]}};

      ld_byte = 8'(mem_rdata >> {eff_off, 3'b000});
      ld_half = eff_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (req_q.funct3)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'h0, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'h0, ld_half};
         default: ld_ext = mem_rdata;
      endcase
   end

   // Next-state and outputs; rejected accesses finish in REQ without touching the bus.
   always_comb begin
      state_nxt    = state;
      issue_ready  = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_be       = 4'b0000;
      mem_wdata    = '0;
      w_ctrl_reg   = 1'b0;
      done         = 1'b0;
      misalign_err = 1'b0;
      case (state)
         IDLE: begin
            issue_ready = 1'b1;
            if (issue_valid) state_nxt = REQ;
         end
         REQ: begin
            if (!go) begin
               done = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
               misalign_err = legal && misaligned;
`endif
               state_nxt = IDLE;
            end else begin
               mem_req   = 1'b1;
               mem_we    = req_q.store;
               mem_addr  = {req_q.addr[addr_length-1:2], 2'b00};
               mem_be    = st_be;
               mem_wdata = st_wdata;
               if (mem_gnt) begin
                  if (req_q.store) begin
                     done      = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     state_nxt = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            if (mem_rvalid) state_nxt = WB;
         end
         WB: begin
            w_ctrl_reg = (req_q.rd != '0);
            done       = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign w_addr_reg = req_q.rd;
   assign w_data_reg = ld_data_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage of the RV32I core; sits directly upstream of regfile and drives its write port (w_addr_reg / w_data_reg / w_ctrl_reg).
- Accepts one load/store from execute, runs a req/gnt/rvalid bus transaction, and lane-aligns store data.
- For loads, extracts and sign/zero-extends the addressed byte/halfword/word and writes it back to the destination register.
- One access in flight at a time.

Parameters:
addr_length, 32, memory address width
data_length, 32, data width (only 32 supported)
register_count, 32, number of architectural registers; sets rd width = $clog2(register_count)

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  synchronous active-high reset
issue_valid  input  1  execute presents an access
issue_ready  output  1  unit can accept (state IDLE)
issue_store  input  1  1 = store, 0 = load
issue_funct3  input  3  RV32I funct3 of the load/store
issue_addr  input  addr_length  effective byte address
issue_wdata  input  data_length  rs2 value for stores
issue_rd  input  $clog2(register_count)  load destination
mem_req  output  1  bus request
mem_we  output  1  write strobe
mem_addr  output  addr_length  word-aligned address (low 2 bits 0)
mem_be  output  4  byte enables
mem_wdata  output  data_length  lane-replicated store data
mem_gnt  input  1  bus accepted request
mem_rvalid  input  1  read data valid
mem_rdata  input  data_length  read word
w_addr_reg  output  $clog2(register_count)  to regfile write address
w_data_reg  output  data_length  to regfile write data
w_ctrl_reg  output  1  to regfile write enable
done  output  1  one-cycle completion pulse
misalign_err  output  1  misaligned-access pulse (feature only)

Behaviour:
- FSM states: IDLE, REQ, WAIT, WB. Reset state is IDLE.
- Reset values: all outputs 0 except issue_ready=1.
- issue_ready = (state==IDLE).
- Accept: on issue_valid && issue_ready, latch store, funct3, addr, wdata and rd, then go to REQ.
- REQ:
  - mem_req=1; mem_addr/mem_we/mem_be/mem_wdata held stable until mem_gnt.
  - On gnt, a store goes to IDLE with done=1 in the gnt cycle.
  - On gnt, a load goes to WAIT.
- WAIT:
  - Waits indefinitely for mem_rvalid; rvalid is sampled only in WAIT.
  - On rvalid, capture the extracted data, then go to WB.
- WB:
  - w_ctrl_reg=1 for exactly one cycle, unless rd==0, in which case w_ctrl_reg stays 0.
  - done=1 in the same cycle; next state IDLE.
  - w_addr_reg and w_data_reg stay valid through WB.
- Load latency: accept at cycle N; with gnt at N+1 and rvalid at N+2, the regfile write happens at N+3. Minimum 3 cycles accept-to-write.
- Offset off = addr[1:0].
  - SB: be = 0001<<off; wdata = {4{wdata[7:0]}}.
  - SH: be = 0011<<off; wdata = {2{wdata[15:0]}}.
  - SW: be = 1111.
  - Loads: be = 1111, mem_we=0.
- Load extraction from rdata:
  - LB (000): byte at lane off, sign-extended.
  - LBU (100): byte at lane off, zero-extended.
  - LH (001): halfword at lanes off[1]*2, sign-extended.
  - LHU (101): halfword at lanes off[1]*2, zero-extended.
  - LW (010): full word.
- Illegal funct3 (load 011/110/111, store other than 000/001/010): no bus access and no writeback; done pulses in the cycle after accept; FSM returns to IDLE.
- Reset mid-operation:
  - FSM goes to IDLE and mem_req drops in the next cycle.
  - A pending grant or late rvalid is ignored; no regfile write occurs.
- issue_valid while busy is ignored (not accepted); upstream must hold it.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - An LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]!=0, makes no bus request and no writeback.
  - misalign_err=1 and done=1 pulse in the cycle after accept; FSM returns to IDLE.
- Undefined:
  - misalign_err is tied 0.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0] (alignment forced).

Test Plan:
- SW 0xDEADBEEF to 0x100, gnt held low 2 cycles -> mem_req stays 1 with stable addr 0x100, be=1111, wdata=0xDEADBEEF; done pulses in the gnt cycle; no regfile write.
- LB rd=5 at 0x203, rdata=0x80FF1234 -> w_ctrl_reg=1 once, w_addr_reg=5, w_data_reg=0xFFFFFF80. Same access as LBU -> 0x00000080.
- LH rd=7 at 0x102, rdata=0x9ABC0000 -> w_data_reg=0xFFFF9ABC. LHU -> 0x00009ABC.
- SB 0x000000A5 to 0x301 -> be=0010, wdata=0xA5A5A5A5, addr=0x300.
- LW rd=0 at 0x40, rdata=0x12345678 -> done pulses, w_ctrl_reg never 1.
- Assert rst in WAIT, then rvalid next cycle -> no write, issue_ready=1 after reset. With LSU_MISALIGN_TRAP_EN, LW at 0x41 -> mem_req never 1, misalign_err=1 and done=1 for one cycle.
